// File: rtl/axi4lite_wb_bridge.sv
// AXI4-Lite slave to Wishbone pipelined master bridge, one transaction at a time.
// Ports:
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   aw*/w*/b*                AXI4-Lite write address, data and response channels
//   ar*/r*                   AXI4-Lite read address and data channels
//   wb_*_o                   Wishbone master cycle/strobe/we/address/select/data
//   wb_*_i                   Wishbone slave ack/err/rty/stall and read data
// Reads and writes alternate when both are pending; every bus cycle is bounded
// by TIMEOUT cycles (0 disables the bound).
module axi4lite_wb_bridge #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-3:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  localparam int unsigned WA    = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, WR_RESP, RD_RESP} state_t;

  state_t state_q, state_d;

  logic          aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [WA-1:0] aw_adr_q, aw_adr_d, ar_adr_q, ar_adr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          last_wr_q, last_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          awready_d, wready_d, arready_d, bvalid_d, rvalid_d;
  logic [1:0]    bresp_d, rresp_d;
  logic [31:0]   rdata_d;
  logic          cyc_d, stb_d, we_d;
  logic [WA-1:0] adr_d;
  logic [3:0]    sel_d;
  logic [31:0]   dat_d;

  // Address byte-offset bits carry no information for word-wide slaves.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  logic aw_hs, w_hs, ar_hs, wr_rdy, rd_rdy, start_wr, start_rd;
  logic accepted, term_any, term_err, tmo;
  logic [CNT_W:0] cnt_inc;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign ar_hs    = arvalid & arready;
  // A handshake in this cycle counts as a full holder so the bus cycle starts next cycle.
  assign wr_rdy   = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign rd_rdy   = ar_full_q | ar_hs;
  assign start_wr = wr_rdy & (~rd_rdy | ~last_wr_q);
  assign start_rd = rd_rdy & ~start_wr;
  assign term_any = wb_ack_i | wb_err_i | wb_rty_i;
  assign term_err = wb_err_i | wb_rty_i;
  assign accepted = (state_q == WB_WAIT) | ~wb_stall_i;
  assign cnt_inc  = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
  assign tmo      = (TIMEOUT != 0) && (cnt_inc == (CNT_W+1)'(TIMEOUT));

  // Next-state, holder and output logic.
  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_adr_d  = aw_adr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_adr_d  = ar_adr_q;
    last_wr_d = last_wr_q;
    cnt_d     = cnt_q;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    rvalid_d  = rvalid;
    rresp_d   = rresp;
    rdata_d   = rdata;
    cyc_d     = wb_cyc_o;
    stb_d     = wb_stb_o;
    we_d      = wb_we_o;
    adr_d     = wb_adr_o;
    sel_d     = wb_sel_o;
    dat_d     = wb_dat_o;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_adr_d  = awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_adr_d  = araddr[ADDR_WIDTH-1:2];
    end

    unique case (state_q)
      IDLE: begin
        if (start_wr) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          last_wr_d = 1'b1;
          cnt_d     = '0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          adr_d     = aw_full_q ? aw_adr_q : awaddr[ADDR_WIDTH-1:2];
          sel_d     = w_full_q ? w_strb_q : wstrb;
          dat_d     = w_full_q ? w_data_q : wdata;
          state_d   = WB_REQ;
        end else if (start_rd) begin
          ar_full_d = 1'b0;
          last_wr_d = 1'b0;
          cnt_d     = '0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b0;
          adr_d     = ar_full_q ? ar_adr_q : araddr[ADDR_WIDTH-1:2];
          sel_d     = 4'hF;
          state_d   = WB_REQ;
        end
      end
      WB_REQ, WB_WAIT: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        // Termination only counts once the strobe has been accepted.
        if ((accepted && term_any) || tmo) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (wb_we_o) begin
            bvalid_d = 1'b1;
            bresp_d  = (term_any && !term_err && accepted) ? RESP_OKAY : RESP_SLVERR;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            if (term_any && !term_err && accepted) begin
              rresp_d = RESP_OKAY;
              rdata_d = wb_dat_i;
            end else begin
              rresp_d = RESP_SLVERR;
              rdata_d = '0;
            end
            state_d = RD_RESP;
          end
        end else if (state_q == WB_REQ && !wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = WB_WAIT;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
    arready_d = ~ar_full_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      aw_adr_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_adr_q  <= '0;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      arready   <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= '0;
      rvalid    <= 1'b0;
      rresp     <= '0;
      rdata     <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_adr_q  <= aw_adr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_adr_q  <= ar_adr_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      awready   <= awready_d;
      wready    <= wready_d;
      arready   <= arready_d;
      bvalid    <= bvalid_d;
      bresp     <= bresp_d;
      rvalid    <= rvalid_d;
      rresp     <= rresp_d;
      rdata     <= rdata_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= stb_d;
      wb_we_o   <= we_d;
      wb_adr_o  <= adr_d;
      wb_sel_o  <= sel_d;
      wb_dat_o  <= dat_d;
    end
  end

endmodule

// File: doc/axi4lite_wb_bridge.md
# axi4lite_wb_bridge

- Converts AXI4-Lite slave transactions into single Wishbone pipelined master cycles.
- Sits directly upstream of the register-bank Wishbone slaves so that an AXI4-Lite interconnect can reach them.
- Handles one transaction at a time, alternates fairly between reads and writes, and bounds every bus cycle with a timeout.

## Interface
- ADDR_WIDTH, 4: byte-address width; Wishbone word address is bits [ADDR_WIDTH-1:2].
- TIMEOUT, 255: maximum cycles with wb_cyc_o high before abort; 0 disables the timeout.
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- awvalid / awready  in / out  1 each  AXI write address handshake.
- awaddr  in  ADDR_WIDTH  write byte address.
- wvalid / wready  in / out  1 each  AXI write data handshake.
- wdata  in  32  write data.
- wstrb  in  4  write byte strobes.
- bvalid / bready  out / in  1 each  AXI write response handshake.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- arvalid / arready  in / out  1 each  AXI read address handshake.
- araddr  in  ADDR_WIDTH  read byte address.
- rvalid / rready  out / in  1 each  AXI read data handshake.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe and write-enable.
- wb_adr_o  out  ADDR_WIDTH-2  word address.
- wb_sel_o  out  4  byte selects.
- wb_dat_o  out  32  write data.
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each  Wishbone slave handshake.
- wb_dat_i  in  32  read data.

## Operation
- **Holding registers**
  - AW, W and AR are captured independently in holding registers.
  - awready = AW holder empty; wready = W holder empty; arready = AR holder empty. All three are registered.
  - A holder clears when its transaction enters WB_REQ.
- **FSM states:** IDLE, WB_REQ, WB_WAIT, WR_RESP, RD_RESP.
- **Transitions**
  - IDLE -> WB_REQ when the AW and W holders are both full (write) or the AR holder is full (read).
  - If both a write and a read are ready, the one not served last wins. After reset the write wins.
  - WB_REQ: cyc=stb=1, with adr/sel/we/dat taken from the holders. For writes, sel=wstrb and we=1; for reads, sel=4'hF and we=0.
  - WB_REQ stays while wb_stall_i=1. Otherwise it goes to WB_WAIT with stb=0 and cyc=1.
  - ack/err/rty can arrive in the same cycle the strobe is accepted; that is handled as an immediate termination.
  - WB_WAIT: on wb_ack_i the response is OKAY. On wb_err_i or wb_rty_i the response is SLVERR. If both ack and err are seen, err wins.
  - On termination: cyc drops the same edge; a read latches rdata=wb_dat_i (on SLVERR it latches 0); next state is WR_RESP or RD_RESP.
- **Timeout**
  - A counter clears on entry to WB_REQ and counts cycles with cyc=1.
  - At count == TIMEOUT the cycle is dropped and the response is SLVERR, with rdata=0.
- **Response states**
  - WR_RESP: bvalid=1 until bready. RD_RESP: rvalid=1 until rready.
  - Each response state returns to IDLE on its handshake.
- **Write strobes:** wstrb=0 still issues a Wishbone write with sel=0.
- **Response fields:** AXI response fields are held stable while valid.
- **Reset**
  - Reset mid-transaction forces IDLE and drops cyc/stb immediately.
  - Reset also empties all holders; no response is issued.

## Timing
- **Reset values**
  - awready, wready, arready, bvalid and rvalid are 0 during reset and in the cycle it is applied.
  - Ready outputs rise the cycle after rst_n_i returns high.
  - Wishbone outputs are all 0 in reset; bresp, rresp and rdata are 0.
- **Latency and throughput**
  - The address/data handshake edge is E. E+1: wb_stb_o=1.
  - A slave acking in the same cycle gives bvalid/rvalid=1 at E+2.
  - Each stall cycle and each wait cycle adds one.
  - Minimum back-to-back throughput is one transaction per 3 cycles with bready/rready held high.
  - A holder may accept the next address while the current transaction is in flight.
- **Write handshake ordering:** AW and W may arrive in any order or cycle; the Wishbone cycle starts the cycle after the later of the two.

## Test plan
- **Single write:** AW addr 0x8, W 0xDEADBEEF, strobe 0xF, slave acks 2 cycles after stb.
  - Required: wb_adr_o=2'b10, wb_sel_o=4'hF, wb_we_o=1 for one stb cycle, bresp=00, bvalid 1 cycle after ack.
- **Single read:** addr 0x4, slave returns 0x00000015.
  - Required: rdata=0x00000015, rresp=00, wb_sel_o=4'hF.
- **Write handshake order:** W handshakes 3 cycles before AW.
  - Required: no stb until the cycle after the AW handshake; awready stays 1 and wready is 0 meanwhile.
- **Simultaneous requests:** write and read pending together from reset, then both re-presented.
  - Required order: write, read, write, read (alternation). wb_stall_i=1 for 4 cycles holds stb and adr stable.
- **Error and timeout:**
  - Case 1: wb_err_i on a write -> bresp=10.
  - Case 2: no ack with TIMEOUT=8 -> cyc drops 8 cycles after rising, rresp=10, rdata=0.
  - Case 3: ack and err together -> SLVERR.
- **Backpressure and reset:**
  - rready held 0 for 5 cycles: rvalid and rdata are stable and no new Wishbone cycle starts.
  - rst_n_i low during WB_WAIT: next cycle cyc=0, all valid outputs 0, holders empty.
